// File: rtl/vga_screen_switch_if.sv
// Bundle of N VGA input streams, the screen-select request and the registered
// pin-side VGA output for vga_screen_switch.
interface vga_screen_switch_if #(
    parameter int N_SCREENS = 4,
    parameter int SEL_W     = 2
);
    logic [N_SCREENS-1:0]    hs_in;
    logic [N_SCREENS-1:0]    vs_in;
    logic [N_SCREENS-1:0]    hblnk_in;
    logic [N_SCREENS-1:0]    vblnk_in;
    logic [12*N_SCREENS-1:0] rgb_in;
    logic [SEL_W-1:0]        sel_req;
    logic                    sel_valid;
    logic                    hs;
    logic                    vs;
    logic [3:0]              r;
    logic [3:0]              g;
    logic [3:0]              b;
    logic [SEL_W-1:0]        active_sel;
    logic                    busy;

    modport master (
        output hs_in, vs_in, hblnk_in, vblnk_in, rgb_in, sel_req, sel_valid,
        input  hs, vs, r, g, b, active_sel, busy
    );

    modport slave (
        input  hs_in, vs_in, hblnk_in, vblnk_in, rgb_in, sel_req, sel_valid,
        output hs, vs, r, g, b, active_sel, busy
    );
endinterface

// File: rtl/vga_screen_switch.sv
// Frame-synchronous selector over N VGA streams with optional fade through black,
// followed by a 2-stage mux / scale+blank output pipeline.
module vga_screen_switch #(
    parameter int N_SCREENS = 4,
    parameter int SEL_W     = 2,
    parameter int INIT_SEL  = 0,
    parameter int FADE_EN   = 1,
    parameter int FADE_STEP = 4
) (
    input logic                pclk,
    input logic                rst,
    vga_screen_switch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

    localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_SCREENS);
    localparam logic [4:0]     STEP  = 5'(FADE_STEP);
    localparam logic [4:0]     FULL  = 5'd16;

    state_t           state;
    logic [SEL_W-1:0] active_sel;
    logic [SEL_W-1:0] pending_sel;
    logic             pending;
    logic [4:0]       level;
    logic             vs_prev;

    logic             sel_hs, sel_vs, sel_hb, sel_vb;
    logic [11:0]      sel_rgb;

    always_comb begin
        sel_hs  = 1'b0;
        sel_vs  = 1'b0;
        sel_hb  = 1'b0;
        sel_vb  = 1'b0;
        sel_rgb = 12'h000;
        for (int i = 0; i < N_SCREENS; i++) begin
            if (active_sel == SEL_W'(i)) begin
                sel_hs  = bus.hs_in[i];
                sel_vs  = bus.vs_in[i];
                sel_hb  = bus.hblnk_in[i];
                sel_vb  = bus.vblnk_in[i];
                sel_rgb = bus.rgb_in[12*i +: 12];
            end
        end
    end

    logic       frame_edge;
    logic       req_ok;
    logic [4:0] level_dn;
    logic [5:0] level_sum;

    assign frame_edge = sel_vs & ~vs_prev;
    assign req_ok     = bus.sel_valid && ({1'b0, bus.sel_req} < N_LIM) &&
                        !(state == IDLE && bus.sel_req == active_sel);
    assign level_dn   = (level > STEP) ? level - STEP : 5'd0;
    assign level_sum  = {1'b0, level} + {1'b0, STEP};

    // Frame-edge FSM first; a request in the same cycle then overrides pending,
    // so it is served at the next edge rather than this one.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            active_sel  <= SEL_W'(INIT_SEL);
            pending_sel <= SEL_W'(INIT_SEL);
            pending     <= 1'b0;
            level       <= FULL;
            vs_prev     <= 1'b1;
        end else begin
            vs_prev <= sel_vs;
            if (frame_edge) begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            if (FADE_EN == 0) begin
                                active_sel <= pending_sel;
                                pending    <= 1'b0;
                                vs_prev    <= 1'b1;
                            end else begin
                                level <= FULL - STEP;
                                state <= FADE_OUT;
                            end
                        end
                    end
                    FADE_OUT: begin
                        if (level == 5'd0) begin
                            active_sel <= pending_sel;
                            pending    <= 1'b0;
                            vs_prev    <= 1'b1;
                            level      <= STEP;
                            state      <= FADE_IN;
                        end else begin
                            level <= level_dn;
                        end
                    end
                    FADE_IN: begin
                        if (level_sum >= 6'd16) begin
                            level <= FULL;
                            state <= IDLE;
                        end else begin
                            level <= level_sum[4:0];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (req_ok) begin
                pending     <= 1'b1;
                pending_sel <= bus.sel_req;
            end
        end
    end

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
        logic [7:0] p;
        p = {4'b0, c} * {3'b0, l};
        return p[7:4];
    endfunction

    logic        s1_hs, s1_vs, s1_hb, s1_vb;
    logic [11:0] s1_rgb;

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_hb  <= 1'b0;
            s1_vb  <= 1'b0;
            s1_rgb <= 12'h000;
            bus.hs <= 1'b0;
            bus.vs <= 1'b0;
            bus.r  <= 4'h0;
            bus.g  <= 4'h0;
            bus.b  <= 4'h0;
        end else begin
            s1_hs  <= sel_hs;
            s1_vs  <= sel_vs;
            s1_hb  <= sel_hb;
            s1_vb  <= sel_vb;
            s1_rgb <= sel_rgb;
            bus.hs <= s1_hs;
            bus.vs <= s1_vs;
            if (s1_hb || s1_vb) begin
                bus.r <= 4'h0;
                bus.g <= 4'h0;
                bus.b <= 4'h0;
            end else begin
                bus.r <= scale(s1_rgb[11:8], level);
                bus.g <= scale(s1_rgb[7:4], level);
                bus.b <= scale(s1_rgb[3:0], level);
            end
        end
    end

    assign bus.active_sel = active_sel;
    assign bus.busy       = (state != IDLE) | pending;
endmodule

// File: tb/tb_vga_screen_switch.sv
// Scoreboard bench: a hard-cut and a fading instance see identical streams and
// requests; expected pixels are queued at drive time and popped two cycles later.
module tb_vga_screen_switch;
    localparam int N    = 3;
    localparam int SW   = 2;
    localparam int STEP = 4;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    always #5 pclk = ~pclk;

    vga_screen_switch_if #(.N_SCREENS(N), .SEL_W(SW)) b0 ();
    vga_screen_switch_if #(.N_SCREENS(N), .SEL_W(SW)) b1 ();

    vga_screen_switch #(.N_SCREENS(N), .SEL_W(SW), .INIT_SEL(0), .FADE_EN(0), .FADE_STEP(STEP))
        u_cut (.pclk(pclk), .rst(rst), .bus(b0.slave));
    vga_screen_switch #(.N_SCREENS(N), .SEL_W(SW), .INIT_SEL(0), .FADE_EN(1), .FADE_STEP(STEP))
        u_fade (.pclk(pclk), .rst(rst), .bus(b1.slave));

    logic [11:0] col [N] = '{12'hFA5, 12'hFFF, 12'h3C7};

    int  checks = 0, errors = 0;
    bit  armed  = 0;
    int  hc = 0, vc = 0;
    int  mst [2], mlvl [2], msel [2], mpsel [2];
    bit  mpend [2], mprev [2];
    logic [13:0] q0 [$];
    logic [13:0] q1 [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] sc(input logic [3:0] c, input int l);
        return 4'((int'(c) * l) / 16);
    endfunction

    function automatic logic [13:0] exp_px(input int u, input bit hsv, input bit vsv, input bit blank);
        logic [11:0] c;
        c = col[msel[u]];
        if (blank) return {hsv, vsv, 12'h000};
        return {hsv, vsv, sc(c[11:8], mlvl[u]), sc(c[7:4], mlvl[u]), sc(c[3:0], mlvl[u])};
    endfunction

    task automatic model(input int u, input bit fade, input bit r, input bit vsv, input bit v, input int rq);
        int st0, sel0;
        bit edge_seen;
        if (r) begin
            mst[u] = 0; mlvl[u] = 16; msel[u] = 0; mpend[u] = 0; mprev[u] = 1;
            return;
        end
        st0 = mst[u];
        sel0 = msel[u];
        edge_seen = vsv && !mprev[u];
        mprev[u] = vsv;
        if (edge_seen) begin
            case (st0)
                0: if (mpend[u]) begin
                    if (!fade) begin
                        msel[u] = mpsel[u]; mpend[u] = 0; mprev[u] = 1;
                    end else begin
                        mlvl[u] = 16 - STEP; mst[u] = 1;
                    end
                end
                1: if (mlvl[u] == 0) begin
                    msel[u] = mpsel[u]; mpend[u] = 0; mprev[u] = 1;
                    mlvl[u] = STEP; mst[u] = 2;
                end else begin
                    mlvl[u] = (mlvl[u] - STEP < 0) ? 0 : mlvl[u] - STEP;
                end
                default: begin
                    mlvl[u] = mlvl[u] + STEP;
                    if (mlvl[u] >= 16) begin mlvl[u] = 16; mst[u] = 0; end
                end
            endcase
        end
        if (v && rq < N && !(st0 == 0 && rq == sel0)) begin
            mpend[u] = 1; mpsel[u] = rq;
        end
    endtask

    task automatic step(input bit r, input bit v, input int rq);
        bit hb, vb, hsv, vsv;
        @(posedge pclk); #1;
        if (armed) begin
            chk("cut_sel",   32'(b0.active_sel), 32'(msel[0]));
            chk("fade_sel",  32'(b1.active_sel), 32'(msel[1]));
            chk("cut_busy",  32'(b0.busy), 32'((mst[0] != 0) || mpend[0]));
            chk("fade_busy", 32'(b1.busy), 32'((mst[1] != 0) || mpend[1]));
            if (q0.size() >= 2) chk("cut_px",  32'({b0.hs, b0.vs, b0.r, b0.g, b0.b}), 32'(q0.pop_front()));
            if (q1.size() >= 2) chk("fade_px", 32'({b1.hs, b1.vs, b1.r, b1.g, b1.b}), 32'(q1.pop_front()));
        end
        hb  = hc >= 12;
        vb  = vc >= 5;
        hsv = (hc == 13) || (hc == 14);
        vsv = vc == 6;
        rst = r;
        b0.hs_in = {N{hsv}};  b1.hs_in = {N{hsv}};
        b0.vs_in = {N{vsv}};  b1.vs_in = {N{vsv}};
        b0.hblnk_in = {N{hb}}; b1.hblnk_in = {N{hb}};
        b0.vblnk_in = {N{vb}}; b1.vblnk_in = {N{vb}};
        b0.sel_valid = v;     b1.sel_valid = v;
        b0.sel_req = SW'(rq); b1.sel_req = SW'(rq);
        if (r) begin
            foreach (q0[i]) q0[i] = 14'h0;
            foreach (q1[i]) q1[i] = 14'h0;
            q0.push_back(14'h0);
            q1.push_back(14'h0);
        end else begin
            q0.push_back(exp_px(0, hsv, vsv, hb || vb));
            q1.push_back(exp_px(1, hsv, vsv, hb || vb));
        end
        model(0, 1'b0, r, vsv, v, rq);
        model(1, 1'b1, r, vsv, v, rq);
        if (r) armed = 1;
        hc++;
        if (hc == 16) begin hc = 0; vc = (vc + 1) % 8; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic go_to(input int v, input int h);
        for (int i = 0; i < 128 && !(vc == v && hc == h); i++) step(0, 0, 0);
    endtask

    task automatic req(input int s);
        step(0, 1, s);
    endtask

    initial begin
        b0.sel_valid = 1'b0; b1.sel_valid = 1'b0;
        b0.sel_req = '0; b1.sel_req = '0;
        for (int i = 0; i < N; i++) begin
            b0.rgb_in[12*i +: 12] = col[i];
            b1.rgb_in[12*i +: 12] = col[i];
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        run(200);

        // 0 -> 1: hard cut on one instance, full fade on the other
        go_to(2, 3); req(1);
        run(128 * 10);
        chk("cut_sel_after_1",   32'(b0.active_sel), 32'd1);
        chk("fade_sel_after_1",  32'(b1.active_sel), 32'd1);
        chk("fade_idle_after_1", 32'(b1.busy), 32'd0);

        // last request wins; out-of-range request 3 ignored
        go_to(1, 2); req(2);
        run(256);
        go_to(3, 2); req(0);
        go_to(3, 5); req(3);
        run(128 * 10);
        chk("cut_sel_after_0",  32'(b0.active_sel), 32'd0);
        chk("fade_sel_after_0", 32'(b1.active_sel), 32'd0);

        // request equal to active screen in IDLE is dropped
        go_to(2, 0); req(0);
        run(3);
        chk("eq_busy_cut",  32'(b0.busy), 32'd0);
        chk("eq_busy_fade", 32'(b1.busy), 32'd0);

        // request on the frame-edge cycle waits a full frame
        go_to(6, 0); req(2);
        run(5);
        chk("coin_pending_cut", 32'(b0.busy), 32'd1);
        chk("coin_sel_cut",     32'(b0.active_sel), 32'd0);
        run(128);
        chk("coin_swap_cut", 32'(b0.active_sel), 32'd2);
        run(128 * 9);

        // reset while fading in
        go_to(2, 0); req(1);
        run(128 * 5 + 64);
        chk("fadein_busy", 32'(b1.busy), 32'd1);
        chk("fadein_sel",  32'(b1.active_sel), 32'd1);
        step(1, 0, 0); step(1, 0, 0);
        run(300);
        chk("post_rst_sel", 32'(b1.active_sel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
